// File: rtl/alsu_pipe_if.sv
// Command/result bus for alsu_pipe: input handshake, operands/controls, output handshake, error indicators.
// err_cnt is present only when ALSU_ERR_CNT_EN is defined.
interface alsu_pipe_if #(
  parameter int WIDTH = 3,
  parameter int LED_W = 16
);
  localparam int OUT_W = 2 * WIDTH;

  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] A;
  logic signed [WIDTH-1:0] B;
  logic                    cin;
  logic                    serial_in;
  logic                    red_op_A;
  logic                    red_op_B;
  logic [2:0]              opcode;
  logic                    bypass_A;
  logic                    bypass_B;
  logic                    direction;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out;
  logic                    err;
  logic [LED_W-1:0]        leds;
`ifdef ALSU_ERR_CNT_EN
  logic [7:0]              err_cnt;

  modport master (
    output in_valid, A, B, cin, serial_in, red_op_A, red_op_B, opcode,
           bypass_A, bypass_B, direction, out_ready,
    input  in_ready, out_valid, out, err, leds, err_cnt
  );

  modport slave (
    input  in_valid, A, B, cin, serial_in, red_op_A, red_op_B, opcode,
           bypass_A, bypass_B, direction, out_ready,
    output in_ready, out_valid, out, err, leds, err_cnt
  );
`else
  modport master (
    output in_valid, A, B, cin, serial_in, red_op_A, red_op_B, opcode,
           bypass_A, bypass_B, direction, out_ready,
    input  in_ready, out_valid, out, err, leds
  );

  modport slave (
    input  in_valid, A, B, cin, serial_in, red_op_A, red_op_B, opcode,
           bypass_A, bypass_B, direction, out_ready,
    output in_ready, out_valid, out, err, leds
  );
`endif
endinterface

// File: rtl/alsu_pipe.sv
// Two-stage pipelined ALSU with valid/ready handshake and a blinking-LED error indicator.
// Define ALSU_ERR_CNT_EN to add a saturating invalid-commit counter (err_cnt) on the bus.
module alsu_pipe #(
  parameter int WIDTH          = 3,
  parameter     INPUT_PRIORITY = "A",
  parameter     FULL_ADDER     = "ON",
  parameter int LED_W          = 16
) (
  input  logic       clk,
  input  logic       rst,
  alsu_pipe_if.slave bus
);
  localparam int OUT_W   = 2 * WIDTH;
  localparam bit PRIO_A  = (INPUT_PRIORITY == "A");
  localparam bit USE_CIN = (FULL_ADDER == "ON");

  localparam logic [2:0] OP_OR     = 3'b000;
  localparam logic [2:0] OP_XOR    = 3'b001;
  localparam logic [2:0] OP_ADD    = 3'b010;
  localparam logic [2:0] OP_MULT   = 3'b011;
  localparam logic [2:0] OP_SHIFT  = 3'b100;
  localparam logic [2:0] OP_ROTATE = 3'b101;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             serialIn;
    logic             redA;
    logic             redB;
    logic [2:0]       opcode;
    logic             bypA;
    logic             bypB;
    logic             dir;
  } cmd_t;

  typedef enum logic {S_IDLE, S_BLINK} blink_e;

  cmd_t             r_s1;
  logic             r_s1_valid;
  logic             r_out_valid;
  logic [OUT_W-1:0] r_out;
  logic             r_err;
  logic [LED_W-1:0] r_leds;
  blink_e           r_state;
  blink_e           w_next_state;
  logic [LED_W-1:0] w_next_leds;

  cmd_t             w_cmd;
  logic             w_adv;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_commit;
  logic             w_invalid;
  logic [WIDTH-1:0] w_red_sel;
  logic [WIDTH-1:0] w_byp_sel;
  logic [OUT_W-1:0] w_a_ext;
  logic [OUT_W-1:0] w_b_ext;
  logic [OUT_W-1:0] w_byp_ext;
  logic [OUT_W-1:0] w_cin_ext;
  logic [OUT_W-1:0] w_result;

  always_comb begin
    w_cmd          = '0;
    w_cmd.a        = bus.A;
    w_cmd.b        = bus.B;
    w_cmd.cin      = bus.cin;
    w_cmd.serialIn = bus.serial_in;
    w_cmd.redA     = bus.red_op_A;
    w_cmd.redB     = bus.red_op_B;
    w_cmd.opcode   = bus.opcode;
    w_cmd.bypA     = bus.bypass_A;
    w_cmd.bypB     = bus.bypass_B;
    w_cmd.dir      = bus.direction;
  end

  // Stage 1 may refill whenever it is empty or its content moves into stage 2.
  assign w_adv      = !r_out_valid || bus.out_ready;
  assign w_in_ready = rst && (!r_s1_valid || w_adv);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_commit   = w_adv && r_s1_valid;

  assign w_invalid = (r_s1.opcode[2:1] == 2'b11) ||
                     ((r_s1.redA || r_s1.redB) && (r_s1.opcode[2:1] != 2'b00));
  assign w_red_sel = (r_s1.redA && (PRIO_A || !r_s1.redB)) ? r_s1.a : r_s1.b;
  assign w_byp_sel = (r_s1.bypA && (PRIO_A || !r_s1.bypB)) ? r_s1.a : r_s1.b;
  assign w_a_ext   = {{WIDTH{r_s1.a[WIDTH-1]}}, r_s1.a};
  assign w_b_ext   = {{WIDTH{r_s1.b[WIDTH-1]}}, r_s1.b};
  assign w_byp_ext = {{WIDTH{w_byp_sel[WIDTH-1]}}, w_byp_sel};
  assign w_cin_ext = {{(OUT_W-1){1'b0}}, USE_CIN & r_s1.cin};

  always_comb begin
    w_result = '0;
    if (w_invalid) begin
      w_result = '0;
    end else if (r_s1.bypA || r_s1.bypB) begin
      w_result = w_byp_ext;
    end else begin
      case (r_s1.opcode)
        OP_OR:     w_result = (r_s1.redA || r_s1.redB) ? {{(OUT_W-1){1'b0}}, |w_red_sel}
                                                       : (w_a_ext | w_b_ext);
        OP_XOR:    w_result = (r_s1.redA || r_s1.redB) ? {{(OUT_W-1){1'b0}}, ^w_red_sel}
                                                       : (w_a_ext ^ w_b_ext);
        OP_ADD:    w_result = w_a_ext + w_b_ext + w_cin_ext;
        OP_MULT:   w_result = $signed(w_a_ext) * $signed(w_b_ext);
        // SHIFT/ROTATE chain off the last committed result held in r_out.
        OP_SHIFT:  w_result = r_s1.dir ? {r_out[OUT_W-2:0], r_s1.serialIn}
                                       : {r_s1.serialIn, r_out[OUT_W-1:1]};
        OP_ROTATE: w_result = r_s1.dir ? {r_out[OUT_W-2:0], r_out[OUT_W-1]}
                                       : {r_out[0], r_out[OUT_W-1:1]};
        default:   w_result = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else if (w_in_ready) begin
      r_s1_valid <= w_accept;
      if (w_accept) r_s1 <= w_cmd;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_err       <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out <= w_result;
        r_err <= w_invalid;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_leds  <= '0;
    end else begin
      r_state <= w_next_state;
      r_leds  <= w_next_leds;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_leds  = r_leds;
    if (w_commit) begin
      if (w_invalid) begin
        w_next_state = S_BLINK;
        w_next_leds  = '1;
      end else begin
        w_next_state = S_IDLE;
        w_next_leds  = '0;
      end
    end else if (r_state == S_BLINK) begin
      w_next_leds = ~r_leds;
    end
  end

`ifdef ALSU_ERR_CNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err_cnt <= '0;
    end else if (w_commit && w_invalid && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign bus.err_cnt = r_err_cnt;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out       = r_out;
  assign bus.err       = r_err;
  assign bus.leds      = r_leds;
endmodule

// File: tb/tb_alsu_pipe.sv
// Self-checking bench for alsu_pipe (WIDTH=3, INPUT_PRIORITY="A", FULL_ADDER="ON").
// Expected results are queued at command acceptance and popped as results are consumed.
module tb_alsu_pipe;
  localparam int WIDTH = 3;
  localparam int LED_W = 16;

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
    logic       cin;
    logic       serialIn;
    logic       redA;
    logic       redB;
    logic [2:0] opcode;
    logic       bypA;
    logic       bypB;
    logic       dir;
  } cmd_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         checks = 0;
  int         failures = 0;
  logic [6:0] expQ[$];
  logic [5:0] modelOut = '0;

  alsu_pipe_if #(.WIDTH(WIDTH), .LED_W(LED_W)) bus ();

  alsu_pipe #(
    .WIDTH(WIDTH), .INPUT_PRIORITY("A"), .FULL_ADDER("ON"), .LED_W(LED_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  function automatic cmd_t mkCmd(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b);
    cmd_t c;
    c = '0;
    c.opcode = op;
    c.a = a;
    c.b = b;
    return c;
  endfunction

  // Reference model for the random test: {err, out}, priority "A", carry-in used.
  function automatic logic [6:0] modelCalc(input cmd_t c, input logic [5:0] prev);
    int a;
    int b;
    int r;
    logic [2:0] sel;
    a = $signed(c.a);
    b = $signed(c.b);
    if (c.opcode > 3'd5 || ((c.redA || c.redB) && c.opcode > 3'd1)) return {1'b1, 6'd0};
    if (c.bypA) return {1'b0, 6'(a)};
    if (c.bypB) return {1'b0, 6'(b)};
    r = 0;
    case (c.opcode)
      3'd0, 3'd1: begin
        if (c.redA || c.redB) begin
          sel = c.redA ? c.a : c.b;
          return {1'b0, 5'd0, (c.opcode == 3'd0) ? |sel : ^sel};
        end
        r = (c.opcode == 3'd0) ? (a | b) : (a ^ b);
      end
      3'd2: r = a + b + (c.cin ? 1 : 0);
      3'd3: r = a * b;
      3'd4: return {1'b0, c.dir ? {prev[4:0], c.serialIn} : {c.serialIn, prev[5:1]}};
      default: return {1'b0, c.dir ? {prev[4:0], prev[5]} : {prev[0], prev[5:1]}};
    endcase
    return {1'b0, 6'(r)};
  endfunction

  task automatic driveCmd(input cmd_t c);
    bus.A         = c.a;
    bus.B         = c.b;
    bus.cin       = c.cin;
    bus.serial_in = c.serialIn;
    bus.red_op_A  = c.redA;
    bus.red_op_B  = c.redB;
    bus.opcode    = c.opcode;
    bus.bypass_A  = c.bypA;
    bus.bypass_B  = c.bypB;
    bus.direction = c.dir;
  endtask

  task automatic sendCmd(input cmd_t c, input logic [5:0] expOut, input logic expErr);
    int waited;
    waited = 0;
    @(negedge clk);
    driveCmd(c);
    bus.in_valid = 1'b1;
    #1;
    while (!bus.in_ready && waited < 200) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!bus.in_ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout in_ready=%b required=1", bus.in_ready);
      bus.in_valid = 1'b0;
    end else begin
      expQ.push_back({expErr, expOut});
      modelOut = expOut;
      @(posedge clk);
    end
  endtask

  task automatic endCmds();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic collect(input int n, input bit randReady, input string tag);
    int got;
    int cycles;
    logic [6:0] exp;
    got = 0;
    cycles = 0;
    while (got < n && cycles < n * 30 + 50) begin
      @(negedge clk);
      bus.out_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      cycles++;
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (expQ.size() == 0) begin
          failures++;
          $display("[TB] FAIL %s_extra out=%b required=no result", tag, bus.out);
        end else begin
          exp = expQ.pop_front();
          if ({bus.err, bus.out} !== exp) begin
            failures++;
            $display("[TB] FAIL %s result%0d out=%b err=%b required out=%b err=%b",
                     tag, got, bus.out, bus.err, exp[5:0], exp[6]);
          end
        end
        got++;
      end
    end
    if (got < n) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_timeout results=%0d required=%0d", tag, got, n);
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.err} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL reset_flags in_ready/out_valid/err=%b required=000",
               {bus.in_ready, bus.out_valid, bus.err});
    end
    checks++;
    if (bus.out !== 6'd0 || bus.leds !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL reset_data out=%b leds=%h required out=000000 leds=0000", bus.out, bus.leds);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_release in_ready=%b required=1", bus.in_ready);
    end
  endtask

  task automatic test_add_latency();
    cmd_t c;
    c = mkCmd(3'd2, 3'd3, 3'd2);
    c.cin = 1'b1;
    @(negedge clk);
    driveCmd(c);
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL add_early out_valid=%b required=0", bus.out_valid);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({bus.out_valid, bus.err, bus.out} !== {1'b1, 1'b0, 6'b000110}) begin
      failures++;
      $display("[TB] FAIL add_result out_valid=%b err=%b out=%b required 1 0 000110",
               bus.out_valid, bus.err, bus.out);
    end
    modelOut = 6'b000110;
  endtask

  task automatic test_shift_rotate();
    cmd_t c1;
    cmd_t c2;
    c1 = mkCmd(3'd4, 3'd0, 3'd0);
    c1.dir = 1'b1;
    c1.serialIn = 1'b1;
    c2 = mkCmd(3'd5, 3'd0, 3'd0);
    fork
      begin
        sendCmd(c1, 6'b001101, 1'b0);
        sendCmd(c2, 6'b100110, 1'b0);
        endCmds();
      end
      collect(2, 1'b0, "shift_rotate");
    join
  endtask

  task automatic test_mult_reduce_bypass();
    cmd_t c[7];
    logic [6:0] e[7];
    c[0] = mkCmd(3'd3, 3'b101, 3'b010);                          e[0] = {1'b0, 6'b111010};
    c[1] = mkCmd(3'd0, 3'b100, 3'b000); c[1].redA = 1; c[1].redB = 1; e[1] = {1'b0, 6'b000001};
    c[2] = mkCmd(3'd2, 3'b100, 3'b000); c[2].redA = 1; c[2].redB = 1; e[2] = {1'b1, 6'b000000};
    c[3] = mkCmd(3'd1, 3'b000, 3'b111); c[3].redB = 1;             e[3] = {1'b0, 6'b000001};
    c[4] = mkCmd(3'd0, 3'b101, 3'b011); c[4].bypA = 1; c[4].bypB = 1; e[4] = {1'b0, 6'b111101};
    c[5] = mkCmd(3'd3, 3'b101, 3'b011); c[5].bypB = 1;             e[5] = {1'b0, 6'b000011};
    c[6] = mkCmd(3'd7, 3'b101, 3'b011); c[6].bypA = 1;             e[6] = {1'b1, 6'b000000};
    fork
      begin
        for (int i = 0; i < 7; i++) sendCmd(c[i], e[i][5:0], e[i][6]);
        endCmds();
      end
      collect(7, 1'b0, "mult_reduce_bypass");
    join
  endtask

  task automatic test_invalid_blink();
    fork
      begin
        sendCmd(mkCmd(3'd6, 3'd1, 3'd1), 6'd0, 1'b1);
        endCmds();
      end
      collect(1, 1'b0, "invalid");
    join
    checks++;
    if (bus.leds !== 16'hFFFF) begin
      failures++;
      $display("[TB] FAIL blink_on leds=%h required=ffff", bus.leds);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.leds !== 16'h0000 || bus.err !== 1'b1) begin
      failures++;
      $display("[TB] FAIL blink_off leds=%h err=%b required leds=0000 err=1", bus.leds, bus.err);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.leds !== 16'hFFFF) begin
      failures++;
      $display("[TB] FAIL blink_on2 leds=%h required=ffff", bus.leds);
    end
    fork
      begin
        sendCmd(mkCmd(3'd0, 3'd1, 3'd2), 6'b000011, 1'b0);
        endCmds();
      end
      collect(1, 1'b0, "recover");
    join
    checks++;
    if (bus.leds !== 16'h0000 || bus.err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL blink_clear leds=%h err=%b required leds=0000 err=0", bus.leds, bus.err);
    end
  endtask

  task automatic test_backpressure();
    cmd_t c3;
    c3 = mkCmd(3'd2, 3'b100, 3'b100);
    c3.cin = 1'b1;
    @(negedge clk);
    #1;
    bus.out_ready = 1'b0;
    fork
      begin
        sendCmd(mkCmd(3'd0, 3'b001, 3'b010), 6'b000011, 1'b0);
        sendCmd(mkCmd(3'd1, 3'b111, 3'b001), 6'b111110, 1'b0);
        sendCmd(c3, 6'b111001, 1'b0);
        endCmds();
      end
      begin
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b01) begin
          failures++;
          $display("[TB] FAIL bp_stall in_ready/out_valid=%b required=01", {bus.in_ready, bus.out_valid});
        end
        checks++;
        if (expQ.size() != 2) begin
          failures++;
          $display("[TB] FAIL bp_accepted count=%0d required=2", expQ.size());
        end
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          #1;
          checks++;
          if ({bus.out_valid, bus.out} !== {1'b1, 6'b000011}) begin
            failures++;
            $display("[TB] FAIL bp_hold%0d out_valid=%b out=%b required 1 000011", i, bus.out_valid, bus.out);
          end
        end
        collect(3, 1'b0, "backpressure");
      end
    join
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    #1;
    @(negedge clk);
    driveCmd(mkCmd(3'd7, 3'd0, 3'd0));
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    driveCmd(mkCmd(3'd2, 3'd1, 3'd1));
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if (bus.leds !== 16'hFFFF) begin
      failures++;
      $display("[TB] FAIL mid_pre_leds leds=%h required=ffff", bus.leds);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.err, bus.leds, bus.out} !== 25'd0) begin
      failures++;
      $display("[TB] FAIL mid_reset out_valid=%b in_ready=%b err=%b leds=%h out=%b required all zero",
               bus.out_valid, bus.in_ready, bus.err, bus.leds, bus.out);
    end
    @(negedge clk);
    rst = 1'b1;
    expQ.delete();
    modelOut = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL mid_stale%0d out_valid=%b out=%b required out_valid=0", i, bus.out_valid, bus.out);
      end
    end
    fork
      begin
        sendCmd(mkCmd(3'd2, 3'd1, 3'd2), 6'b000011, 1'b0);
        endCmds();
      end
      collect(1, 1'b0, "after_reset");
    join
  endtask

  task automatic test_random();
    cmd_t c;
    logic [6:0] e;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          c = 16'($urandom);
          c.redA = ($urandom_range(0, 5) == 0);
          c.redB = ($urandom_range(0, 5) == 0);
          c.bypA = ($urandom_range(0, 6) == 0);
          c.bypB = ($urandom_range(0, 6) == 0);
          e = modelCalc(c, modelOut);
          sendCmd(c, e[5:0], e[6]);
        end
        endCmds();
      end
      collect(40, 1'b1, "random");
    join
  endtask

  initial begin
    driveCmd('0);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_add_latency();
    test_shift_rotate();
    test_mult_reduce_bypass();
    test_invalid_blink();
    test_backpressure();
    test_reset_midstream();
    test_random();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
